// File: rtl/dataSizes.sv
// Width constants shared by the playback datapath.
package dataSizes;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 6;
endpackage

// File: rtl/dataTypes.sv
// State encoding for the playback sequencer.
package dataTypes;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pbState_t;
endpackage

// File: rtl/oneshot.sv
// Rising-edge detector: one pulse per low-to-high transition of din.
module oneshot (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic pulse
);

  logic prevQ;

  always_ff @(posedge clk) begin
    if (!resetN) prevQ <= 1'b0;
    else         prevQ <= din;
  end

  assign pulse = din & ~prevQ;

endmodule

// File: rtl/playback_unit.sv
// Serializes 32-bit words LSB first, one bit per enabled samplePulse edge,
// with a one-word holding register for gapless back-to-back playback.
module playback_unit
  import dataSizes::*;
  import dataTypes::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              enable,
  input  logic              samplePulse,
  input  logic [WORD_W-1:0] wordIn,
  input  logic              wordValid,
  output logic              wordReady,
  output logic              dOut,
  output logic              busy,
  output logic              wordDone,
  output logic              underrun,
  output logic [CNT_W-1:0]  bitCount
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  pbState_t          state;
  logic [WORD_W-1:0] holding;
  logic [WORD_W-1:0] shift;
  logic              holdFull;
  logic              edgePulse;
  logic              step;
  logic              accept;

  oneshot uEdge (
    .clk    (clk),
    .resetN (resetN),
    .din    (samplePulse),
    .pulse  (edgePulse)
  );

  assign step      = enable & edgePulse;
  assign wordReady = ~holdFull | ~resetN;
  assign accept    = wordValid & ~holdFull;
  assign busy      = (state == RUN);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= IDLE;
      holding  <= '0;
      holdFull <= 1'b0;
      shift    <= '0;
      bitCount <= '0;
      dOut     <= IDLE_LEVEL;
      wordDone <= 1'b0;
      underrun <= 1'b0;
    end else begin
      wordDone <= 1'b0;
      // accept and reload are exclusive: reload needs holdFull, accept needs it clear
      if (accept) begin
        holding  <= wordIn;
        holdFull <= 1'b1;
      end
      if (!enable) underrun <= 1'b0;
      if (step) begin
        unique case (state)
          IDLE: begin
            if (holdFull) begin
              shift    <= holding;
              holdFull <= 1'b0;
              bitCount <= '0;
              dOut     <= holding[0];
              state    <= RUN;
            end
          end
          RUN: begin
            if (bitCount != LAST) begin
              shift    <= {IDLE_LEVEL, shift[WORD_W-1:1]};
              dOut     <= shift[1];
              bitCount <= bitCount + CNT_W'(1);
            end else begin
              wordDone <= 1'b1;
              if (holdFull) begin
                shift    <= holding;
                holdFull <= 1'b0;
                bitCount <= '0;
                dOut     <= holding[0];
              end else begin
                dOut     <= IDLE_LEVEL;
                bitCount <= '0;
                underrun <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_playback_unit.sv
// Randomized and directed bench for playback_unit with a word-level model.
module tb_playback_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        enable;
  logic        samplePulse;
  logic [31:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic        dOut;
  logic        busy;
  logic        wordDone;
  logic        underrun;
  logic [5:0]  bitCount;

  always #5 clk = ~clk;

  playback_unit #(.IDLE_LEVEL(1'b1)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .samplePulse (samplePulse),
    .wordIn      (wordIn),
    .wordValid   (wordValid),
    .wordReady   (wordReady),
    .dOut        (dOut),
    .busy        (busy),
    .wordDone    (wordDone),
    .underrun    (underrun),
    .bitCount    (bitCount)
  );

  typedef struct packed {
    logic       dOut;
    logic       busy;
    logic [5:0] cnt;
    logic       done;
    logic       und;
    logic       rdy;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   monOn = 0;

  // Word-level reference: current word + bit index, plus pending words.
  logic [31:0] mCur;
  int          mIdx;
  bit          mCurV;
  logic [31:0] pend[$];
  bit          mUnder;
  bit          mDone;
  bit          mPrevSp;

  task automatic modelEdge(input logic rst, input logic en, input logic sp,
                           input logic wv, input logic [31:0] w);
    bit st;
    bit rdy;
    if (!rst) begin
      mCurV = 0; mIdx = 0; pend.delete();
      mUnder = 0; mDone = 0; mPrevSp = 0;
    end else begin
      st = en && sp && !mPrevSp;
      mPrevSp = sp;
      mDone = 0;
      rdy = (pend.size() == 0);
      if (!en) mUnder = 0;
      if (st) begin
        if (mCurV) begin
          if (mIdx < 31) mIdx++;
          else begin
            mDone = 1;
            if (pend.size() > 0) begin
              mCur = pend.pop_front(); mIdx = 0;
            end else begin
              mCurV = 0; mIdx = 0; mUnder = 1;
            end
          end
        end else if (pend.size() > 0) begin
          mCur = pend.pop_front(); mIdx = 0; mCurV = 1;
        end
      end
      if (wv && rdy) pend.push_back(w);
    end
  endtask

  task automatic cycle(input logic rst, input logic en, input logic sp,
                       input logic wv, input logic [31:0] w);
    exp_t e;
    @(negedge clk);
    resetN = rst; enable = en; samplePulse = sp;
    wordValid = wv; wordIn = w;
    modelEdge(rst, en, sp, wv, w);
    e.dOut = mCurV ? mCur[mIdx] : 1'b1;
    e.busy = mCurV;
    e.cnt  = mCurV ? 6'(mIdx) : 6'd0;
    e.done = mDone;
    e.und  = mUnder;
    e.rdy  = (pend.size() == 0);
    expQ.push_back(e);
    monOn = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 32'h0);
  endtask

  task automatic stepOnce(input logic en);
    cycle(1, en, 1, 0, 32'h0);
    cycle(1, en, 0, 0, 32'h0);
  endtask

  task automatic load(input logic [31:0] w);
    cycle(1, 1, 0, 1, w);
  endtask

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (monOn) begin
        cyc++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL scoreboard-empty cycle %0d", cyc);
        end else begin
          e = expQ.pop_front();
          if ({dOut, busy, bitCount, wordDone, underrun, wordReady} !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d got dOut=%b busy=%b cnt=%0d done=%b und=%b rdy=%b expected dOut=%b busy=%b cnt=%0d done=%b und=%b rdy=%b",
                     cyc, dOut, busy, bitCount, wordDone, underrun, wordReady,
                     e.dOut, e.busy, e.cnt, e.done, e.und, e.rdy);
          end
        end
      end
    end
  end

  initial begin
    resetN = 0; enable = 1; samplePulse = 0; wordValid = 0; wordIn = '0;
    cycle(0, 1, 0, 0, 32'h0);
    cycle(0, 1, 1, 1, 32'h1234_5678);
    idle(2);

    // step in idle with nothing queued
    stepOnce(1);
    idle(2);

    // single word, full playback then underrun
    load(32'hA5A5_0F01);
    for (int i = 0; i < 32; i++) stepOnce(1);
    stepOnce(1);
    idle(2);

    // two words back to back
    load(32'h0000_0000);
    stepOnce(1);
    load(32'hFFFF_FFFF);
    for (int i = 0; i < 64; i++) stepOnce(1);
    idle(2);

    // held samplePulse gives one step
    load(32'h0F0F_3C3C);
    stepOnce(1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 32'h0);
    cycle(1, 1, 0, 0, 32'h0);

    // freeze at bitCount 12, then resume
    for (int i = 0; i < 11; i++) stepOnce(1);
    for (int i = 0; i < 5; i++) stepOnce(0);
    for (int i = 0; i < 21; i++) stepOnce(1);
    idle(2);

    // late accept at the last bit is not reloaded
    load(32'h8000_0001);
    for (int i = 0; i < 32; i++) stepOnce(1);
    cycle(1, 1, 1, 1, 32'h5555_AAAA);
    cycle(1, 1, 0, 0, 32'h0);
    stepOnce(1);
    stepOnce(1);

    // reset mid-word with holding full
    load(32'hDEAD_BEEF);
    stepOnce(1);
    load(32'hCAFE_F00D);
    for (int i = 0; i < 20; i++) stepOnce(1);
    cycle(0, 1, 0, 0, 32'h0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 4000; i++)
      cycle(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0),
            $urandom);

    @(posedge clk);
    #3;
    monOn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
